// File: rtl/rom_loader_sms.sv
// ROM download loader: strips an optional copier header, packs bytes into 16-bit words,
// queues them in a small FIFO and writes them to cartridge SDRAM over a req/ack port.
module rom_loader_sms #(
  parameter int ADDR_W     = 22,
  parameter int FIFO_DEPTH = 4,
  parameter int HDR_BYTES  = 512
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              hdr_skip,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [ADDR_W-2:0] mem_addr,
  output logic [15:0]       mem_din,
  output logic [1:0]        mem_be,
  output logic [ADDR_W-1:0] rom_mask,
  output logic              busy,
  output logic              load_done,
  output logic              overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = ADDR_W - 1 + 18;

  // state | meaning
  // IDLE  | waiting for download rise     LOAD  | accepting bytes
  // FLUSH | push leftover partial word    DRAIN | wait for FIFO and port to empty
  // DONE  | rom_mask valid, behaves as IDLE
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FLUSH, S_DRAIN, S_DONE} state_t;

  state_t              state_q;
  logic                dl_q, skip_q, part_vld_q, any_q, ovf_q, hold_q;
  logic [ADDR_W-2:0]   part_addr_q;
  logic [7:0]          part_byte_q;
  logic [ADDR_W-1:0]   last_q, rom_mask_q;
  logic [EW-1:0]       fifo_q [FIFO_DEPTH];
  logic [PW-1:0]       wptr_q, rptr_q;
  logic [PW:0]         cnt_q;
  logic                mem_req_q, busy_q, done_q;
  logic [ADDR_W-2:0]   mem_addr_q;
  logic [15:0]         mem_din_q;
  logic [1:0]          mem_be_q;

  logic                rise, fall, abort, pop, hdr_drop, oor, stale;
  logic                part_set, part_clr, ovf_set, acc;
  logic [24:0]         b_off;
  logic [ADDR_W-2:0]   wa;
  logic [PW:0]         free, need, push_n;
  logic [EW-1:0]       ent0, ent1, stale_ent;
  logic [ADDR_W-1:0]   smear, mask_d;

  assign rise      = ioctl_download & ~dl_q;
  assign fall      = ~ioctl_download & dl_q;
  assign abort     = rise & ((state_q == S_FLUSH) | (state_q == S_DRAIN));
  assign pop       = mem_req_q & mem_ack & ~hold_q;
  assign b_off     = ioctl_addr - (skip_q ? 25'(HDR_BYTES) : 25'd0);
  assign hdr_drop  = skip_q && (ioctl_addr < 25'(HDR_BYTES));
  assign oor       = |b_off[24:ADDR_W];
  assign wa        = b_off[ADDR_W-1:1];
  assign stale     = part_vld_q && (part_addr_q != wa);
  assign free      = (PW+1)'(FIFO_DEPTH) - cnt_q;
  assign stale_ent = {part_addr_q, 8'h00, part_byte_q, 2'b01};

  always_comb begin
    push_n   = '0;
    need     = '0;
    ent0     = '0;
    ent1     = '0;
    part_set = 1'b0;
    part_clr = 1'b0;
    ovf_set  = 1'b0;
    acc      = 1'b0;
    if (state_q == S_LOAD && ioctl_wr && !hdr_drop) begin
      if (oor) begin
        ovf_set = 1'b1;
      end else begin
        acc = 1'b1;
        if (!b_off[0]) begin
          part_set = 1'b1;
          ent0     = stale_ent;
          if (stale) begin
            if (free != '0) push_n = (PW+1)'(1);
            else            ovf_set = 1'b1;
          end
        end else begin
          // An odd byte always consumes the partial; with too few slots the newest entry is lost.
          part_clr = 1'b1;
          if (stale) begin
            ent0 = stale_ent;
            ent1 = {wa, ioctl_dout, 8'h00, 2'b10};
            need = (PW+1)'(2);
          end else begin
            ent0 = part_vld_q ? {wa, ioctl_dout, part_byte_q, 2'b11}
                              : {wa, ioctl_dout, 8'h00, 2'b10};
            need = (PW+1)'(1);
          end
          if (free >= need) begin
            push_n = need;
          end else begin
            push_n  = free;
            ovf_set = 1'b1;
          end
        end
      end
    end else if (state_q == S_FLUSH && !rise && part_vld_q) begin
      part_clr = 1'b1;
      ent0     = stale_ent;
      if (free != '0) push_n = (PW+1)'(1);
      else            ovf_set = 1'b1;
    end
  end

  always_comb begin
    smear = '0;
    smear[ADDR_W-1] = last_q[ADDR_W-1];
    for (int i = ADDR_W - 2; i >= 0; i--) smear[i] = smear[i+1] | last_q[i];
    mask_d = (any_q ? smear : '0) | ADDR_W'(16'h3FFF);
  end

  always_ff @(posedge clk_sys) begin
    if (push_n != '0)            fifo_q[wptr_q]           <= ent0;
    if (push_n == (PW+1)'(2))    fifo_q[wptr_q + PW'(1)]  <= ent1;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      dl_q        <= 1'b0;
      skip_q      <= 1'b0;
      part_vld_q  <= 1'b0;
      part_addr_q <= '0;
      part_byte_q <= '0;
      last_q      <= '0;
      any_q       <= 1'b0;
      ovf_q       <= 1'b0;
      hold_q      <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      mem_be_q    <= '0;
      rom_mask_q  <= ADDR_W'(16'h3FFF);
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      dl_q   <= ioctl_download;
      done_q <= 1'b0;

      if (mem_req_q) begin
        if (mem_ack) begin
          mem_req_q <= 1'b0;
          hold_q    <= 1'b0;
        end
      end else if (cnt_q != '0 && !abort) begin
        {mem_addr_q, mem_din_q, mem_be_q} <= fifo_q[rptr_q];
        mem_req_q <= 1'b1;
      end

      // A restart mid-drain discards queued words; a request already on the port is held to completion.
      if (abort) begin
        wptr_q     <= '0;
        rptr_q     <= '0;
        cnt_q      <= '0;
        part_vld_q <= 1'b0;
        if (mem_req_q && !mem_ack) hold_q <= 1'b1;
      end else begin
        wptr_q <= wptr_q + push_n[PW-1:0];
        rptr_q <= rptr_q + PW'(pop);
        cnt_q  <= cnt_q + push_n - (PW+1)'(pop);
        if (part_set) begin
          part_vld_q  <= 1'b1;
          part_addr_q <= wa;
          part_byte_q <= ioctl_dout;
        end else if (part_clr) begin
          part_vld_q  <= 1'b0;
        end
      end

      if (rise) begin
        ovf_q  <= 1'b0;
        last_q <= '0;
        any_q  <= 1'b0;
        skip_q <= hdr_skip;
      end else begin
        if (ovf_set) ovf_q <= 1'b1;
        if (acc) begin
          any_q <= 1'b1;
          if (b_off[ADDR_W-1:0] > last_q) last_q <= b_off[ADDR_W-1:0];
        end
      end

      case (state_q)
        S_IDLE, S_DONE: if (rise) begin
          state_q <= S_LOAD;
          busy_q  <= 1'b1;
        end
        S_LOAD:  if (fall) state_q <= S_FLUSH;
        S_FLUSH: state_q <= rise ? S_LOAD : S_DRAIN;
        S_DRAIN: if (rise) begin
          state_q <= S_LOAD;
        end else if (cnt_q == '0 && !mem_req_q) begin
          state_q    <= S_DONE;
          busy_q     <= 1'b0;
          done_q     <= 1'b1;
          rom_mask_q <= mask_d;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;
  assign mem_be    = mem_be_q;
  assign rom_mask  = rom_mask_q;
  assign busy      = busy_q;
  assign load_done = done_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_rom_loader_sms.sv
// Bench for rom_loader_sms: byte-stream stimulus with a word-level reference model feeding a
// write scoreboard; a monitor checks every accepted SDRAM write against it.
module tb_rom_loader_sms;

  localparam int DEPTH = 4;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        hdr_skip = 1'b0;
  logic        mem_ack = 1'b0;
  logic        mem_req;
  logic [20:0] mem_addr;
  logic [15:0] mem_din;
  logic [1:0]  mem_be;
  logic [21:0] rom_mask;
  logic        busy, load_done, overflow;

  rom_loader_sms dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .hdr_skip(hdr_skip), .mem_req(mem_req), .mem_ack(mem_ack), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_be(mem_be), .rom_mask(rom_mask), .busy(busy),
    .load_done(load_done), .overflow(overflow)
  );

  always #5 clk_sys = ~clk_sys;

  int errors = 0;
  int checks = 0;
  int ack_mode = 0;   // 0 always accept, 1 random 0..3 cycle delay, 2 stall
  int ack_dly = -1;
  int done_cnt = 0;

  // reference model state
  logic [38:0] exp_q[$];
  bit          m_pv, m_ovf, m_skip, m_any;
  int unsigned m_pa, m_last;
  logic [7:0]  m_pb;

  logic        prev_req = 1'b0;
  logic [38:0] prev_v = '0;
  logic [38:0] cur_v, exp_v;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void m_push(int unsigned wa, logic [15:0] din, logic [1:0] be);
    if (exp_q.size() < DEPTH) exp_q.push_back({21'(wa), din, be});
    else m_ovf = 1'b1;
  endfunction

  function automatic void model_byte(int unsigned a, logic [7:0] d);
    int unsigned b, wa;
    if (m_skip && a < 512) return;
    b = m_skip ? a - 512 : a;
    if (b >= (32'd1 << 22)) begin
      m_ovf = 1'b1;
      return;
    end
    m_any = 1'b1;
    if (b > m_last) m_last = b;
    wa = b / 2;
    if (b % 2 == 0) begin
      if (m_pv && m_pa != wa) m_push(m_pa, {8'h00, m_pb}, 2'b01);
      m_pv = 1'b1;
      m_pa = wa;
      m_pb = d;
    end else begin
      if (m_pv && m_pa == wa) m_push(wa, {d, m_pb}, 2'b11);
      else begin
        if (m_pv) m_push(m_pa, {8'h00, m_pb}, 2'b01);
        m_push(wa, {d, 8'h00}, 2'b10);
      end
      m_pv = 1'b0;
    end
  endfunction

  function automatic logic [21:0] m_mask();
    int msb;
    if (!m_any) return 22'h3FFF;
    msb = 0;
    for (int i = 0; i < 22; i++) if (m_last[i]) msb = i;
    return 22'(((64'd1 << (msb + 1)) - 64'd1) | 64'h3FFF);
  endfunction

  // ack driver
  initial begin
    forever begin
      @(negedge clk_sys);
      if (ack_mode == 0) mem_ack = 1'b1;
      else if (ack_mode == 2) mem_ack = 1'b0;
      else if (!mem_req) begin
        mem_ack = 1'b0;
        ack_dly = -1;
      end else begin
        if (ack_dly < 0) ack_dly = $urandom_range(0, 3);
        mem_ack = (ack_dly == 0);
        if (ack_dly > 0) ack_dly--;
      end
    end
  end

  // monitor: a transfer happens on the next rising edge when req&ack are seen here
  initial begin
    forever begin
      @(negedge clk_sys);
      #1;
      cur_v = {mem_addr, mem_din, mem_be};
      if (load_done) done_cnt++;
      if (prev_req && mem_req) chk("req_stable", cur_v, prev_v);
      if (mem_req && mem_ack) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL write_unexpected: got 0x%0h expected none", cur_v);
        end else begin
          exp_v = exp_q.pop_front();
          chk("write", cur_v, exp_v);
        end
      end
      prev_req = mem_req && !mem_ack;
      prev_v   = cur_v;
    end
  end

  task automatic start_load(bit skip);
    @(negedge clk_sys);
    hdr_skip = skip;
    ioctl_download = 1'b1;
    m_skip = skip;
    m_ovf = 1'b0;
    m_any = 1'b0;
    m_last = 0;
    m_pv = 1'b0;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic wr_byte(int unsigned a, logic [7:0] d, int gap);
    ioctl_addr = a[24:0];
    ioctl_dout = d;
    ioctl_wr = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    model_byte(a, d);
    repeat (gap) @(negedge clk_sys);
  endtask

  task automatic end_load();
    int d0;
    bit seen;
    d0 = done_cnt;
    ioctl_download = 1'b0;
    if (m_pv) m_push(m_pa, {8'h00, m_pb}, 2'b01);
    m_pv = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_sys);
      if (done_cnt != d0) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL load_done_timeout: got none expected a pulse");
    end
    repeat (4) @(negedge clk_sys);
    chk("load_done_count", 64'(done_cnt), 64'(d0 + 1));
    chk("rom_mask", rom_mask, m_mask());
    chk("overflow", overflow, m_ovf);
    chk("busy_after", busy, 0);
    chk("pending_writes", 64'(exp_q.size()), 0);
  endtask

  initial begin
    int d0, n;
    int unsigned a;
    logic [38:0] e;

    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    @(negedge clk_sys);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_din", mem_din, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_rom_mask", rom_mask, 22'h3FFF);
    chk("rst_busy", busy, 0);
    chk("rst_load_done", load_done, 0);
    chk("rst_overflow", overflow, 0);

    // plain 8-byte load
    ack_mode = 0;
    start_load(1'b0);
    chk("busy_load", busy, 1);
    for (int i = 0; i < 8; i++) wr_byte(i, 8'(i), 0);
    end_load();

    // copier header stripped
    start_load(1'b1);
    for (int i = 0; i < 516; i++) wr_byte(i, 8'($urandom), 0);
    end_load();

    // odd length -> trailing low-byte word on flush
    start_load(1'b0);
    for (int i = 0; i < 5; i++) wr_byte(i, 8'hC0 + 8'(i), 1);
    end_load();

    // stalled port fills the FIFO
    ack_mode = 2;
    start_load(1'b0);
    for (int i = 0; i < 16; i++) wr_byte(i, 8'hA0 + 8'(i), 0);
    chk("stall_overflow", overflow, m_ovf);
    chk("stall_req", mem_req, 1);
    chk("stall_addr", mem_addr, 0);
    repeat (8) @(negedge clk_sys);
    ack_mode = 0;
    end_load();

    // large image mask and out-of-range byte
    start_load(1'b0);
    wr_byte(32'h20000, 8'h5A, 2);
    wr_byte(32'h400000, 8'h11, 2);
    end_load();

    // reset during drain
    ack_mode = 2;
    start_load(1'b0);
    for (int i = 0; i < 6; i++) wr_byte(i, 8'h30 + 8'(i), 0);
    ioctl_download = 1'b0;
    repeat (4) @(negedge clk_sys);
    chk("drain_busy", busy, 1);
    chk("drain_req", mem_req, 1);
    d0 = done_cnt;
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_req", mem_req, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_mask", rom_mask, 22'h3FFF);
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    exp_q.delete();
    m_pv = 1'b0;
    chk("rst_no_done", 64'(done_cnt), 64'(d0));
    ack_mode = 0;
    start_load(1'b0);
    for (int i = 0; i < 4; i++) wr_byte(i, 8'h70 + 8'(i), 0);
    end_load();

    // restart while draining: outstanding word completes, rest discarded
    ack_mode = 2;
    start_load(1'b0);
    for (int i = 0; i < 4; i++) wr_byte(i, 8'h90 + 8'(i), 0);
    ioctl_download = 1'b0;
    repeat (4) @(negedge clk_sys);
    e = exp_q[0];
    exp_q.delete();
    exp_q.push_back(e);
    ack_mode = 0;
    start_load(1'b0);
    for (int i = 0; i < 6; i++) wr_byte(100 + i, 8'(i), 2);
    end_load();

    // randomized loads
    for (int it = 0; it < 8; it++) begin
      ack_mode = 1;
      start_load(1'($urandom_range(0, 1)));
      n = $urandom_range(1, 30);
      a = m_skip ? $urandom_range(0, 700) : $urandom_range(0, 300);
      for (int k = 0; k < n; k++) begin
        if (k > 0) begin
          case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: a = a + 1;
            9:       a = 32'h400200 + $urandom_range(0, 3);
            default: a = $urandom_range(0, 2000);
          endcase
        end
        wr_byte(a, 8'($urandom), $urandom_range(8, 10));
      end
      end_load();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

endmodule
